// File: rtl/uart_mem_bridge_pkg.sv
// Shared constants for the UART-to-memory debug bridge:
// command/reply bytes and the controller state encoding.
package uart_bridge_pkg;

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam logic [7:0] RSP_BAD = 8'h3F;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t GET_ADDR = 3'd1;
    localparam state_t GET_DATA = 3'd2;
    localparam state_t BUS_REQ  = 3'd3;
    localparam state_t TX_RESP  = 3'd4;
    localparam state_t TX_WAIT  = 3'd5;

endpackage

// File: rtl/uart_mem_bridge_if.sv
// PicoRV32-style native memory bus between the bridge
// (master) and the addressed slave.
interface uart_mem_bridge_if;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_instr, mem_addr,
        output mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr,
        input  mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/uart_mem_bridge.sv
// Debug/boot bridge: turns 'W'/'R' command bytes from a UART
// receiver into single native-bus cycles and replies over UART.
module uart_mem_bridge #(
    parameter logic [23:0] RX_TIMEOUT  = 24'd1_000_000,
    parameter logic [15:0] BUS_TIMEOUT = 16'd1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic       overrun,
    uart_mem_bridge_if.master mem
);

    import uart_bridge_pkg::*;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cmd;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_resp;
    logic [2:0]  r_resp_cnt;
    logic [23:0] r_rx_tmr;
    logic [15:0] r_bus_tmr;
    logic        r_tx_start;
    logic [7:0]  r_tx_byte;
    logic        r_overrun;

    logic w_rx_to;
    logic w_bus_to;
    logic w_last;
    logic w_is_rw;
    logic w_busy_st;
    logic w_mem_valid;
    logic w_fire;
    logic w_tx_done;

    assign w_rx_to   = (r_rx_tmr == RX_TIMEOUT - 24'd1);
    assign w_bus_to  = (r_bus_tmr == BUS_TIMEOUT - 16'd1);
    assign w_last    = (r_byte_cnt == 2'd3);
    assign w_is_rw   = (rx_byte == CMD_W) || (rx_byte == CMD_R);
    assign w_busy_st = (r_state == BUS_REQ) ||
                       (r_state == TX_RESP) ||
                       (r_state == TX_WAIT);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:
                if (rx_valid) w_next = w_is_rw ? GET_ADDR : TX_RESP;
            GET_ADDR:
                if (rx_valid && w_last)
                    w_next = (r_cmd == CMD_W) ? GET_DATA : BUS_REQ;
                else if (!rx_valid && w_rx_to)
                    w_next = IDLE;
            GET_DATA:
                if (rx_valid && w_last)        w_next = BUS_REQ;
                else if (!rx_valid && w_rx_to) w_next = IDLE;
            BUS_REQ:
                if (mem.mem_ready || w_bus_to) w_next = TX_RESP;
            TX_RESP:
                if (!tx_busy) w_next = TX_WAIT;
            TX_WAIT:
                if (w_tx_done)
                    w_next = (r_resp_cnt == 3'd1) ? IDLE : TX_RESP;
            default: w_next = IDLE;
        endcase
    end

    // The strobe itself marks the first TX_WAIT cycle, when busy is not yet valid.
    always_comb begin
        w_mem_valid = (r_state == BUS_REQ);
        w_fire      = (r_state == TX_RESP) && !tx_busy;
        w_tx_done   = (r_state == TX_WAIT) && !r_tx_start && !tx_busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd      <= 8'h00;
            r_byte_cnt <= 2'd0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_resp     <= 32'h0;
            r_resp_cnt <= 3'd0;
            r_rx_tmr   <= 24'd0;
            r_bus_tmr  <= 16'd0;
            r_tx_start <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_overrun  <= 1'b0;
        end else begin
            r_tx_start <= w_fire;
            if (w_fire) r_tx_byte <= r_resp[31:24];
            if (rx_valid && w_busy_st) r_overrun <= 1'b1;
            if (r_state != BUS_REQ) r_bus_tmr <= 16'd0;
            case (r_state)
                IDLE: if (rx_valid) begin
                    r_cmd      <= rx_byte;
                    r_byte_cnt <= 2'd0;
                    r_rx_tmr   <= 24'd0;
                    if (!w_is_rw) begin
                        r_resp     <= {RSP_BAD, 24'h0};
                        r_resp_cnt <= 3'd1;
                    end
                end
                GET_ADDR: if (rx_valid) begin
                    r_addr     <= {r_addr[23:0], rx_byte};
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    r_rx_tmr   <= 24'd0;
                end else begin
                    r_rx_tmr <= r_rx_tmr + 24'd1;
                end
                GET_DATA: if (rx_valid) begin
                    r_wdata    <= {r_wdata[23:0], rx_byte};
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    r_rx_tmr   <= 24'd0;
                end else begin
                    r_rx_tmr <= r_rx_tmr + 24'd1;
                end
                BUS_REQ: if (mem.mem_ready) begin
                    if (r_cmd == CMD_W) begin
                        r_resp     <= {RSP_OK, 24'h0};
                        r_resp_cnt <= 3'd1;
                    end else begin
                        r_resp     <= mem.mem_rdata;
                        r_resp_cnt <= 3'd4;
                    end
                end else if (w_bus_to) begin
                    r_resp     <= {RSP_ERR, 24'h0};
                    r_resp_cnt <= 3'd1;
                end else begin
                    r_bus_tmr <= r_bus_tmr + 16'd1;
                end
                TX_WAIT: if (w_tx_done) begin
                    r_resp     <= {r_resp[23:0], 8'h00};
                    r_resp_cnt <= r_resp_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign tx_start      = r_tx_start;
    assign tx_byte       = r_tx_byte;
    assign overrun       = r_overrun;
    assign mem.mem_valid = w_mem_valid;
    assign mem.mem_instr = 1'b0;
    assign mem.mem_addr  = {r_addr[31:2], 2'b00};
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_wstrb = (w_mem_valid && r_cmd == CMD_W) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge with a UART transmitter
// model and a native-bus slave model driven on the falling edge.
module tb_uart_mem_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       overrun;

    uart_mem_bridge_if m();

    uart_mem_bridge #(
        .RX_TIMEOUT (24'd40),
        .BUS_TIMEOUT(16'd16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .tx_busy (tx_busy),
        .tx_start(tx_start),
        .tx_byte (tx_byte),
        .overrun (overrun),
        .mem     (m.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bench-controlled slave behaviour
    int          slave_delay = 0;
    logic [31:0] slave_data  = 32'h0;
    bit          stray       = 1'b0;

    // Model-owned observations
    int          cyc = 0;
    int          ntx = 0;
    int          n_txn = 0;
    int          vcyc = 0;
    int          ready_cyc = -1;
    int          busy_cnt = 0;
    int          tx_cyc [64];
    logic [7:0]  txq [64];
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    bit          prev_start = 1'b0;
    bit          pend = 1'b0;
    bit          prev_valid = 1'b0;
    bit          slave_r;

    always @(negedge clk) begin
        cyc++;
        if (tx_start) begin
            check("tx_start_when_busy",
                  {31'b0, tx_busy | prev_start}, 32'h0);
            if (ntx < 64) begin
                txq[ntx]    = tx_byte;
                tx_cyc[ntx] = cyc;
            end
            ntx++;
            pend = 1'b1;
        end else if (pend) begin
            pend     = 1'b0;
            tx_busy  = 1'b1;
            busy_cnt = 4;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
        prev_start = tx_start;

        slave_r = 1'b0;
        if (m.mem_valid) begin
            if (!prev_valid) begin
                n_txn++;
                cap_addr  = m.mem_addr;
                cap_wdata = m.mem_wdata;
                cap_wstrb = m.mem_wstrb;
                vcyc      = 0;
            end else begin
                check("addr_hold", m.mem_addr, cap_addr);
                check("wdata_hold", m.mem_wdata, cap_wdata);
            end
            vcyc++;
            slave_r = (slave_delay >= 0) && (vcyc == slave_delay + 1);
            if (slave_r) ready_cyc = cyc;
        end
        prev_valid  = m.mem_valid;
        m.mem_ready = slave_r | stray;
        m.mem_rdata = slave_data;
    end

    typedef struct {
        logic [71:0] cmd;
        int          nb;
        int          delay;
        logic [31:0] rdata;
        int          exp_txn;
        int          exp_vcyc;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        int          exp_ntx;
        logic [31:0] exp_tx;
    } vec_t;

    vec_t vecs [5];

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int target);
        for (int k = 0; k < 400 && ntx < target; k++) @(negedge clk);
        repeat (20) @(negedge clk);
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        int          b0, t0;
        logic [31:0] et;
        v  = vecs[i];
        et = v.exp_tx;
        b0 = ntx;
        t0 = n_txn;
        slave_delay = v.delay;
        slave_data  = v.rdata;
        for (int b = 0; b < v.nb; b++) send_byte(v.cmd[71-8*b -: 8]);
        if (v.exp_txn > 0)
            check($sformatf("v%0d_valid_latency", i), {31'b0, m.mem_valid}, 32'h1);
        wait_tx(b0 + v.exp_ntx);
        check($sformatf("v%0d_txn", i), n_txn - t0, v.exp_txn);
        check($sformatf("v%0d_ntx", i), ntx - b0, v.exp_ntx);
        for (int k = 0; k < v.exp_ntx; k++)
            check($sformatf("v%0d_tx%0d", i, k), {24'h0, txq[b0+k]},
                  {24'h0, et[31-8*k -: 8]});
        if (v.exp_txn > 0) begin
            check($sformatf("v%0d_addr", i), cap_addr, v.exp_addr);
            check($sformatf("v%0d_wstrb", i), {28'h0, cap_wstrb},
                  {28'h0, v.exp_wstrb});
            check($sformatf("v%0d_valid_cycles", i), vcyc, v.exp_vcyc);
            if (v.exp_wstrb == 4'hF)
                check($sformatf("v%0d_wdata", i), cap_wdata, v.exp_wdata);
            if (v.delay >= 0)
                check($sformatf("v%0d_ready_to_tx", i),
                      {31'b0, (tx_cyc[b0] - ready_cyc) >= 2}, 32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0, t0;

        vecs[0] = '{{8'h57, 32'h0000_1004, 32'hDEAD_BEEF}, 9, 3, 32'h0,
                    1, 4, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 1, 32'h4B00_0000};
        vecs[1] = '{{8'h52, 32'h0000_2000, 32'h0}, 5, 1, 32'h1234_5678,
                    1, 2, 32'h0000_2000, 32'h0, 4'h0, 4, 32'h1234_5678};
        vecs[2] = '{{8'h52, 32'h0000_0007, 32'h0}, 5, 0, 32'hA5A5_0001,
                    1, 1, 32'h0000_0004, 32'h0, 4'h0, 4, 32'hA5A5_0001};
        vecs[3] = '{{8'h41, 64'h0}, 1, 0, 32'h0,
                    0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h3F00_0000};
        vecs[4] = '{{8'h52, 32'h0000_3000, 32'h0}, 5, -1, 32'h0,
                    1, 16, 32'h0000_3000, 32'h0, 4'h0, 1, 32'h4500_0000};

        repeat (3) @(negedge clk);
        check("rst_tx_start", {31'b0, tx_start}, 32'h0);
        check("rst_tx_byte", {24'h0, tx_byte}, 32'h0);
        check("rst_overrun", {31'b0, overrun}, 32'h0);
        check("rst_mem_valid", {31'b0, m.mem_valid}, 32'h0);
        check("rst_mem_instr", {31'b0, m.mem_instr}, 32'h0);
        check("rst_mem_addr", m.mem_addr, 32'h0);
        check("rst_mem_wdata", m.mem_wdata, 32'h0);
        check("rst_mem_wstrb", {28'h0, m.mem_wstrb}, 32'h0);
        rst = 1'b0;

        // mem_ready with no request pending
        stray = 1'b1;
        repeat (5) @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_ready_txn", n_txn, 0);
        check("stray_ready_tx", ntx, 0);

        for (int i = 0; i < 5; i++) run_vec(i);
        check("no_overrun_yet", {31'b0, overrun}, 32'h0);

        // partial command abandoned after inter-byte silence
        b0 = ntx;
        t0 = n_txn;
        send_byte(8'h57);
        send_byte(8'h00);
        repeat (45) @(negedge clk);
        check("rxto_no_txn", n_txn - t0, 0);
        check("rxto_no_tx", ntx - b0, 0);
        send_byte(8'h41);
        wait_tx(b0 + 1);
        check("rxto_idle_ntx", ntx - b0, 1);
        check("rxto_idle_reply", {24'h0, txq[b0]}, 32'h3F);
        check("rxto_idle_txn", n_txn - t0, 0);

        // byte injected while the reply is being sent
        b0 = ntx;
        t0 = n_txn;
        slave_delay = 0;
        slave_data  = 32'hCAFE_0042;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h08);
        for (int k = 0; k < 100 && !tx_start; k++) @(negedge clk);
        check("ovr_tx_seen", {31'b0, tx_start}, 32'h1);
        send_byte(8'h41);
        wait_tx(b0 + 4);
        check("ovr_set", {31'b0, overrun}, 32'h1);
        check("ovr_ntx", ntx - b0, 4);
        check("ovr_tx0", {24'h0, txq[b0]},   32'hCA);
        check("ovr_tx1", {24'h0, txq[b0+1]}, 32'hFE);
        check("ovr_tx2", {24'h0, txq[b0+2]}, 32'h00);
        check("ovr_tx3", {24'h0, txq[b0+3]}, 32'h42);
        check("ovr_addr", cap_addr, 32'h0000_0008);
        b0 = ntx;
        send_byte(8'h41);
        wait_tx(b0 + 1);
        check("ovr_sticky", {31'b0, overrun}, 32'h1);
        check("ovr_next_reply", {24'h0, txq[b0]}, 32'h3F);

        // reset while a bus cycle is outstanding
        slave_delay = -1;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        check("mid_valid_before", {31'b0, m.mem_valid}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_valid_dropped", {31'b0, m.mem_valid}, 32'h0);
        check("mid_tx_start_low", {31'b0, tx_start}, 32'h0);
        check("mid_overrun_clr", {31'b0, overrun}, 32'h0);
        rst = 1'b0;
        b0 = ntx;
        repeat (30) @(negedge clk);
        check("mid_no_reply", ntx - b0, 0);
        run_vec(1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
